// File: rtl/fwft_64x512_afull.sv
// rtl/fwft_64x512_afull.sv - 64x512 first-word-fall-through FIFO with almost-full flag at 480
module fwft_64x512_afull (
    input  logic        clk,
    input  logic        srst,
    input  logic [63:0] din,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [63:0] dout,
    output logic        empty,
    output logic        valid,
    output logic        prog_full
);
    localparam logic [9:0] C_FULL   = 10'd512;
    localparam logic [9:0] C_AFULL  = 10'd480;

    logic [63:0] r_mem [0:511];
    logic [8:0]  r_wr_ptr;
    logic [8:0]  r_rd_ptr;
    logic [9:0]  r_count;
    logic [63:0] r_dout;
    logic        r_valid;
    logic        r_prog_full;

    logic        w_pop;
    logic        w_wr_acc;
    logic        w_mem_nonempty;
    logic        w_load;
    logic [9:0]  w_count_next;

    // The output register holds the head word; the RAM never holds more than 511
    // entries, so pointer equality means the RAM side is empty.
    assign w_pop          = rd_en & r_valid;
    assign w_wr_acc       = wr_en & ((r_count != C_FULL) | w_pop);
    assign w_mem_nonempty = (r_rd_ptr != r_wr_ptr);
    assign w_load         = w_mem_nonempty & (~r_valid | w_pop);
    assign w_count_next   = r_count + {9'd0, w_wr_acc} - {9'd0, w_pop};

    always_ff @(posedge clk) begin
        if (!srst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr    <= 9'd0;
            r_rd_ptr    <= 9'd0;
            r_count     <= 10'd0;
            r_dout      <= 64'd0;
            r_valid     <= 1'b0;
            r_prog_full <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 9'd1;
            end
            if (w_load) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 9'd1;
                r_valid  <= 1'b1;
            end else if (w_pop) begin
                r_valid  <= 1'b0;
            end
            r_count     <= w_count_next;
            r_prog_full <= (w_count_next >= C_AFULL);
        end
    end

    assign dout      = r_dout;
    assign empty     = ~r_valid;
    assign valid     = r_valid;
    assign prog_full = r_prog_full;
endmodule

// File: tb/tb_fwft_64x512_afull.sv
// tb/tb_fwft_64x512_afull.sv - directed self-checking bench for fwft_64x512_afull
module tb_fwft_64x512_afull;
    logic        clk = 1'b0;
    logic        srst;
    logic [63:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [63:0] dout;
    logic        empty;
    logic        valid;
    logic        prog_full;

    int n_pass = 0;
    int n_total = 0;

    fwft_64x512_afull dut (
        .clk       (clk),
        .srst      (srst),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .valid     (valid),
        .prog_full (prog_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        srst = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);

        // Reset held 3 cycles with writes requested
        srst = 1'b1; wr_en = 1'b1; din = 64'h55;
        repeat (3) tick();
        srst = 1'b0; wr_en = 1'b0;
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_pfull", {63'd0, prog_full}, 64'd0);
        chk("rst_dout", dout, 64'd0);
        tick();
        chk("rst_nostore", {63'd0, empty}, 64'd1);

        // First-word fall-through
        din = 64'h8; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("fwft_not_yet", {63'd0, empty}, 64'd1);
        tick();
        chk("fwft_dout", dout, 64'h8);
        chk("fwft_empty", {63'd0, empty}, 64'd0);
        chk("fwft_valid", {63'd0, valid}, 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fwft_pop_empty", {63'd0, empty}, 64'd1);
        chk("fwft_dout_hold", dout, 64'h8);

        // Burst of 4 then drain at one word per cycle
        for (int i = 0; i < 4; i++) begin
            din = 64'h10 + 64'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("burst_dout", dout, 64'h10 + 64'(i));
            chk("burst_empty", {63'd0, empty}, 64'd0);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("burst_done_empty", {63'd0, empty}, 64'd1);

        // Simultaneous read and write at occupancy 4
        for (int i = 0; i < 4; i++) begin
            din = 64'h20 + 64'(i); wr_en = 1'b1;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            chk("rw_dout", dout, 64'h20 + 64'(i));
            chk("rw_empty", {63'd0, empty}, 64'd0);
            din = 64'h24 + 64'(i); wr_en = 1'b1; rd_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rw_drain", dout, 64'h28 + 64'(i));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("rw_occ4_empty", {63'd0, empty}, 64'd1);

        // Fill with 520 writes; 512 stored, prog_full after the 480th
        for (int i = 0; i < 520; i++) begin
            din = 64'(i); wr_en = 1'b1;
            tick();
            if (i == 478) chk("pf_low_479", {63'd0, prog_full}, 64'd0);
            if (i == 479) chk("pf_rise_480", {63'd0, prog_full}, 64'd1);
        end
        chk("full_pf", {63'd0, prog_full}, 64'd1);
        chk("full_head", dout, 64'd0);
        // Read+write while full: pop 0, accept 0x1234
        din = 64'h1234; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("full_rw_pf", {63'd0, prog_full}, 64'd1);
        for (int j = 1; j <= 512; j++) begin
            chk("fill_order", dout, (j == 512) ? 64'h1234 : 64'(j));
            rd_en = 1'b1;
            tick();
            if (j == 32) chk("pf_hold_480", {63'd0, prog_full}, 64'd1);
            if (j == 33) chk("pf_fall_479", {63'd0, prog_full}, 64'd0);
            if (j == 511) chk("fill_lastword", {63'd0, empty}, 64'd0);
        end
        chk("fill_drained", {63'd0, empty}, 64'd1);

        // Underflow attempts are ignored
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        chk("uf_empty", {63'd0, empty}, 64'd1);
        chk("uf_dout_hold", dout, 64'h1234);

        // Mid-stream reset discards queued words
        for (int i = 0; i < 5; i++) begin
            din = 64'h50 + 64'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("mrst_empty", {63'd0, empty}, 64'd1);
        chk("mrst_dout", dout, 64'd0);
        din = 64'hAA; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        chk("mrst_first", dout, 64'hAA);
        chk("mrst_valid", {63'd0, valid}, 64'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mrst_only_one", {63'd0, empty}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fwft_64x512_afull.md
# fwft_64x512_afull

First-word-fall-through synchronous FIFO, 64 bits wide and 512 words deep, with a programmable almost-full flag. Processing elements use it as an input synchronisation buffer. It decouples an upstream producer, which has no per-word handshake and only honours back-pressure, from a consumer that pops only when data is present. The head word is always presented on `dout` without a prior read, and `rd_en` acknowledges (pops) it.

## Interface
- No parameters. Width 64, depth 512 and almost-full threshold 480 are fixed.
- `clk` in 1: single clock. All logic on the rising edge.
- `srst` in 1: reset, synchronous, active-high.
- `din` in 64: write data.
- `wr_en` in 1: write strobe, sampled at the rising edge.
- `rd_en` in 1: pop the current head word.
- `dout` out 64: head-of-queue word, valid while `empty`=0.
- `empty` out 1: no word available on `dout`.
- `valid` out 1: equal to ~`empty`; `dout` holds a real word.
- `prog_full` out 1: almost full; occupancy ≥ 480.

## Operation
- Occupancy counts every stored word, including a word already presented on `dout`. Range 0..512.
- **Write:** `wr_en`=1 and occupancy<512 stores `din` at the tail. If occupancy=512, the write is silently dropped and no state changes.
- **Read:** `rd_en`=1 and `empty`=0 pops the head word. `rd_en` while `empty`=1 is ignored. Read never underflows.
- **Simultaneous read and write:** with occupancy in 1..511, both take effect and occupancy is unchanged. At occupancy 512, the read frees a slot and the write is accepted in the same cycle.
- Words come out in write order; no loss except writes dropped when full.
- `prog_full` is a single threshold with no hysteresis: 1 when occupancy ≥ 480, else 0.
  - This leaves 32 words of slack for producers that react to back-pressure late.
- `dout` holds its last value while `empty`=1. It changes only when a new head word is loaded.
- **Reset:** `srst`=1 at an edge clears all contents and occupancy. It overrides `wr_en`/`rd_en` in that cycle.
  - After the edge: `empty`=1, `valid`=0, `prog_full`=0, `dout`=0.
  - A reset mid-stream discards all queued words.
- Storage may be block RAM with synchronous read. The FWFT prefetch/output stage hides that read latency.

## Timing
- **Write-to-empty latency:** a word written at edge k into an empty FIFO appears on `dout` with `empty`=0 after edge k+1. It is never visible after edge k itself.
- **Throughput:** back-to-back reads sustain one word per cycle whenever enough words are stored. After a pop at edge k, the next word appears on `dout` right after edge k, and `empty` stays 0.
- **Last word:** popping the last stored word at edge k sets `empty`=1 after edge k, unless a write at edge k-1 or earlier will land it.
- A word written at edge k is counted in occupancy, and hence in `prog_full`, right after edge k.
- `prog_full` rises after the edge where occupancy reaches 480. It falls after the edge where occupancy drops to 479.
- Writes sustain one per cycle until occupancy=512.
- Outputs are register-driven; there is no combinational path from `din`/`wr_en`/`rd_en` to outputs.
- `rd_en` may be generated combinationally from `empty`.

## Test plan
- **Reset:** hold `srst` 3 cycles while `wr_en`=1 -> `empty`=1, `valid`=0, `prog_full`=0, `dout`=0, and no words stored.
- **First-word fall-through:** write 0x8 at edge k into an empty FIFO -> after edge k+1, `dout`=0x8 and `empty`=0. Pulse `rd_en` one cycle -> `empty`=1.
- **Burst:** write 0x10..0x13 on consecutive cycles, then hold `rd_en`=~`empty` -> `dout` shows 0x10,0x11,0x12,0x13 on consecutive cycles, then `empty`=1.
- **Simultaneous read and write:** 0x20..0x23 stored, then 8 cycles with `wr_en`=`rd_en`=1 writing 0x24..0x2B -> output order 0x20..0x2B and occupancy steady at 4.
- **Fill and overflow:** write 520 words 0..519 with no reads -> `prog_full` rises after the 480th write. Only 0..511 are read back, and `empty`=1 after 512 pops.
- **Underflow and mid-stream reset:** `rd_en`=1 while empty has no effect. Write 5 words, assert `srst` -> `empty`=1, and the next written word 0xAA is the first word read.
